// File: rtl/window_feeder_pkg.sv
// window_feeder_pkg: shared types and sizing helpers for the window feeder.
//   state_t          - feeder FSM states
//   calc_window_len  - window length N = 2**WINDOW_SIZE_BITS + MAX_TAU
//   cnt_width        - bits needed to hold 0..max_val
package window_feeder_pkg;

  typedef enum logic [2:0] {
    FILL,
    LAUNCH,
    RUN,
    CAPTURE,
    WAIT_HOP
  } state_t;

  function automatic int unsigned calc_window_len(input int unsigned wsb,
                                                  input int unsigned max_tau);
    return (32'd1 << wsb) + max_tau;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/window_feeder_if.sv
// window_feeder_if: sample stream into the window feeder.
//   s_valid - sample offered (source -> feeder)
//   s_ready - feeder accepts on s_valid & s_ready at a rising edge
//   s_data  - signed sample, DATA_WIDTH bits
// Modports: master = sample source, slave = window feeder.
interface window_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/window_feeder_sample_shift_buffer.sv
// sample_shift_buffer: DEPTH-entry sample shift register plus a snapshot copy.
//   clk, reset  - clock, asynchronous active-low reset (clears both arrays)
//   shift_en    - shift one sample in: entry k <= entry k+1, entry DEPTH-1 <= shift_data
//   shift_data  - incoming sample
//   load        - snapshot <= current registered shift contents
//   snapshot    - flat snapshot, entry k at [k*DATA_WIDTH +: DATA_WIDTH], k=0 oldest
module sample_shift_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 296
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        shift_en,
  input  logic [DATA_WIDTH-1:0]       shift_data,
  input  logic                        load,
  output logic [DEPTH*DATA_WIDTH-1:0] snapshot
);

  logic [DEPTH*DATA_WIDTH-1:0] shift_q;
  logic [DEPTH*DATA_WIDTH-1:0] snap_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      snap_q  <= '0;
    end else begin
      if (shift_en) begin
        shift_q <= {shift_data, shift_q[DEPTH*DATA_WIDTH-1:DATA_WIDTH]};
      end
      // Takes the pre-edge contents, so a sample shifted on the same edge is excluded.
      if (load) begin
        snap_q <= shift_q;
      end
    end
  end

  assign snapshot = snap_q;

endmodule

// File: rtl/window_feeder.sv
// window_feeder: assembles the flat analysis window for the minimum-tau
// detector, launches one analysis every HOP accepted samples and returns each
// detected period as a one-cycle strobe. Owns the detector's reset line.
//   clk         - clock
//   reset       - asynchronous active-low reset
//   s_if        - sample stream (slave modport: s_valid, s_ready, s_data)
//   det_reset   - synchronous active-high reset to the detector
//   det_data    - window snapshot, sample k at [k*DATA_WIDTH +: DATA_WIDTH], k=0 oldest
//   det_ready   - detector done (held until det_reset)
//   det_min_tau - detector result, 0 = no period
//   tau_valid   - one-cycle result strobe
//   tau         - last captured result
//   overrun     - sticky: at least one launch was skipped
// Build option: WINDOW_FEEDER_BACKPRESSURE_EN - when defined, s_ready drops in
// RUN once HOP samples are pending, so no launch is ever skipped.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned WINDOW_SIZE_BITS = 8,
  parameter int unsigned MAX_TAU          = 40,
  parameter int unsigned HOP              = 64,
  parameter int unsigned DET_RESET_CYCLES = 2,
  localparam int unsigned N = calc_window_len(WINDOW_SIZE_BITS, MAX_TAU)
) (
  input  logic                    clk,
  input  logic                    reset,
  window_feeder_if.slave          s_if,
  output logic                    det_reset,
  output logic [N*DATA_WIDTH-1:0] det_data,
  input  logic                    det_ready,
  input  logic [7:0]              det_min_tau,
  output logic                    tau_valid,
  output logic [7:0]              tau,
  output logic                    overrun
);

  localparam int unsigned FILL_W = cnt_width(N);
  localparam int unsigned HOP_W  = cnt_width(HOP);
  localparam int unsigned RST_W  = cnt_width(DET_RESET_CYCLES);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [HOP_W-1:0]  HOP_FULL  = HOP_W'(HOP);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(DET_RESET_CYCLES - 1);

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q;
  logic [HOP_W-1:0]    hop_q, hop_d;
  logic [RST_W-1:0]    rst_cnt_q;
  logic                first_run_q;
  logic                s_ready_q, s_ready_d;
  logic                det_reset_q;
  logic [7:0]          tau_q;
  logic                overrun_q, overrun_set;
  logic                accept;
  logic                enter_launch;

  assign accept = s_if.s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:     if (fill_q == FILL_FULL) state_d = LAUNCH;
      LAUNCH:   if (rst_cnt_q == RST_LAST) state_d = RUN;
      RUN:      if (det_ready && !first_run_q) state_d = CAPTURE;
      CAPTURE:  state_d = (hop_q == HOP_FULL) ? LAUNCH : WAIT_HOP;
      WAIT_HOP: if (hop_q == HOP_FULL) state_d = LAUNCH;
      default:  state_d = FILL;
    endcase
  end

  always_comb begin
    enter_launch = (state_d == LAUNCH) && (state_q != LAUNCH);
    hop_d        = hop_q;
    if (enter_launch) begin
      // The sample accepted on the launch edge is not in the snapshot, so it
      // is the first one of the next hop.
      hop_d = accept ? HOP_W'(1) : '0;
    end else if (accept && (hop_q != HOP_FULL)) begin
      hop_d = hop_q + 1'b1;
    end
  end

  always_comb begin
`ifdef WINDOW_FEEDER_BACKPRESSURE_EN
    // Registered from next-state values: low exactly while RUN has a full hop.
    s_ready_d   = !((state_d == RUN) && (hop_d == HOP_FULL));
    overrun_set = 1'b0;
`else
    s_ready_d   = 1'b1;
    overrun_set = accept && (state_q == RUN) && (hop_q == HOP_FULL);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      fill_q      <= '0;
      hop_q       <= '0;
      rst_cnt_q   <= '0;
      first_run_q <= 1'b0;
      s_ready_q   <= 1'b0;
      det_reset_q <= 1'b1;
      tau_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hop_q       <= hop_d;
      first_run_q <= (state_q == LAUNCH);
      s_ready_q   <= s_ready_d;
      det_reset_q <= (state_d == LAUNCH);
      if (accept && (fill_q != FILL_FULL)) begin
        fill_q <= fill_q + 1'b1;
      end
      if (state_q == LAUNCH) begin
        rst_cnt_q <= rst_cnt_q + 1'b1;
      end else begin
        rst_cnt_q <= '0;
      end
      // Result is latched on the edge entering CAPTURE, together with the strobe.
      if ((state_q == RUN) && (state_d == CAPTURE)) begin
        tau_q <= det_min_tau;
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  sample_shift_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (N)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (accept),
    .shift_data (s_if.s_data),
    .load       (enter_launch),
    .snapshot   (det_data)
  );

  assign s_if.s_ready = s_ready_q;
  assign det_reset    = det_reset_q;
  assign tau_valid    = (state_q == CAPTURE);
  assign tau          = tau_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: directed self-checking bench for window_feeder
// (DATA_WIDTH=16 so ramp samples above 255 stay distinct).
module tb_window_feeder;

  localparam int DW  = 16;
  localparam int N   = 296;
  localparam int HOP = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          det_reset;
  logic [N*DW-1:0] det_data;
  logic          det_ready;
  logic [7:0]    det_min_tau;
  logic          tau_valid;
  logic [7:0]    tau;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Detector model: done det_delay cycles after its reset falls, or manual.
  int         det_delay      = 10;
  int         det_cnt        = 0;
  logic       det_manual     = 1'b0;
  logic       det_manual_val = 1'b0;
  logic [7:0] det_tau_val    = 8'd0;

  window_feeder_if #(.DATA_WIDTH(DW)) sif ();

  window_feeder #(
    .DATA_WIDTH       (DW),
    .WINDOW_SIZE_BITS (8),
    .MAX_TAU          (40),
    .HOP              (HOP),
    .DET_RESET_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_if        (sif),
    .det_reset   (det_reset),
    .det_data    (det_data),
    .det_ready   (det_ready),
    .det_min_tau (det_min_tau),
    .tau_valid   (tau_valid),
    .tau         (tau),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (det_reset) det_cnt <= 0;
    else if (det_cnt < 100000) det_cnt <= det_cnt + 1;
  end

  assign det_ready   = det_manual ? det_manual_val : (!det_reset && (det_cnt >= det_delay));
  assign det_min_tau = det_tau_val;

  function automatic logic [DW-1:0] sample_at(input int k);
    return det_data[k*DW +: DW];
  endfunction

  // Called at a negedge; pushes n ramp samples starting at first, returns at
  // the negedge after the last accept with s_valid low.
  task automatic push(input int n, input int first, output int low_cycles);
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    low_cycles = 0;
    while (sent < n && guard < 4000) begin
      sif.s_valid = 1'b1;
      sif.s_data  = DW'(first + sent);
      if (sif.s_ready === 1'b1) sent++;
      else low_cycles++;
      @(negedge clk);
      guard++;
    end
    sif.s_valid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL push_timeout: accepted %0d required %0d", sent, n);
    end
  endtask

  task automatic wait_det_reset(input logic level, input int bound);
    int c;
    c = 0;
    while (det_reset !== level && c < bound) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (det_reset !== level) begin
      errors++;
      $display("FAIL wait_det_reset: got %b required %b within %0d cycles", det_reset, level, bound);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL rst_det_reset: got %b required 1", det_reset); end
    checks++; if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b required 0", sif.s_ready); end
    checks++; if (tau_valid !== 1'b0) begin errors++; $display("FAIL rst_tau_valid: got %b required 0", tau_valid); end
    checks++; if (tau !== 8'd0) begin errors++; $display("FAIL rst_tau: got %0d required 0", tau); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b required 0", overrun); end
    checks++; if (det_data !== '0) begin errors++; $display("FAIL rst_det_data: got nonzero required 0"); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sif.s_ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready: got %b required 1", sif.s_ready); end
    checks++; if (det_reset !== 1'b0) begin errors++; $display("FAIL rel_det_reset: got %b required 0", det_reset); end
  endtask

  task automatic test_fill_launch;
    int low;
    int w;
    det_delay = 10;
    det_tau_val = 8'd17;
    push(N, 0, low);
    checks++; if (det_reset !== 1'b0) begin errors++; $display("FAIL fill_early_launch: det_reset %b required 0", det_reset); end
    @(negedge clk);
    checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL fill_launch_edge: det_reset %b required 1", det_reset); end
    w = 0;
    while (det_reset === 1'b1 && w < 20) begin
      w++;
      @(negedge clk);
    end
    checks++; if (w != 2) begin errors++; $display("FAIL det_reset_width: got %0d required 2", w); end
    checks++; if (sample_at(0) !== 16'd0) begin errors++; $display("FAIL snap1_s0: got %0d required 0", sample_at(0)); end
    checks++; if (sample_at(150) !== 16'd150) begin errors++; $display("FAIL snap1_s150: got %0d required 150", sample_at(150)); end
    checks++; if (sample_at(295) !== 16'd295) begin errors++; $display("FAIL snap1_s295: got %0d required 295", sample_at(295)); end
  endtask

  task automatic test_detect;
    int c;
    int hi;
    c = 0;
    while (det_ready !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++; if (det_ready !== 1'b1) begin errors++; $display("FAIL det_ready_timeout: got %b required 1", det_ready); end
    checks++; if (tau_valid !== 1'b0) begin errors++; $display("FAIL tv_early: got %b required 0", tau_valid); end
    @(negedge clk);
    checks++; if (tau_valid !== 1'b1) begin errors++; $display("FAIL tv_strobe: got %b required 1", tau_valid); end
    checks++; if (tau !== 8'd17) begin errors++; $display("FAIL tau_first: got %0d required 17", tau); end
    @(negedge clk);
    checks++; if (tau_valid !== 1'b0) begin errors++; $display("FAIL tv_one_cycle: got %b required 0", tau_valid); end
    checks++; if (tau !== 8'd17) begin errors++; $display("FAIL tau_held: got %0d required 17", tau); end
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (det_reset === 1'b1) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL wait_hop_idle: det_reset high %0d cycles required 0", hi); end
  endtask

  task automatic test_hop;
    int low;
    int c;
    det_tau_val = 8'd33;
    push(HOP - 1, N, low);
    repeat (4) @(negedge clk);
    checks++; if (det_reset !== 1'b0) begin errors++; $display("FAIL hop_early: det_reset %b required 0", det_reset); end
    push(1, N + HOP - 1, low);
    @(negedge clk);
    checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL hop_launch: det_reset %b required 1", det_reset); end
    checks++; if (sample_at(0) !== 16'd64) begin errors++; $display("FAIL snap2_s0: got %0d required 64", sample_at(0)); end
    checks++; if (sample_at(295) !== 16'd359) begin errors++; $display("FAIL snap2_s295: got %0d required 359", sample_at(295)); end
    c = 0;
    while (tau_valid !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++; if (tau_valid !== 1'b1) begin errors++; $display("FAIL tv2_timeout: got %b required 1", tau_valid); end
    checks++; if (tau !== 8'd33) begin errors++; $display("FAIL tau_second: got %0d required 33", tau); end
  endtask

  task automatic test_overrun;
    int low;
    det_delay = 200;
    det_tau_val = 8'd5;
    @(negedge clk);
    push(HOP + 100, 360, low);
`ifdef WINDOW_FEEDER_BACKPRESSURE_EN
    checks++; if (low == 0) begin errors++; $display("FAIL bp_s_ready_low: low cycles %0d required >0", low); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun: got %b required 0", overrun); end
`else
    checks++; if (low != 0) begin errors++; $display("FAIL ovr_s_ready: low cycles %0d required 0", low); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
`endif
  endtask

  task automatic test_mid_reset;
    int low;
    wait_det_reset(1'b1, 400);
    wait_det_reset(1'b0, 20);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL mid_det_reset: got %b required 1", det_reset); end
    checks++; if (tau_valid !== 1'b0) begin errors++; $display("FAIL mid_tau_valid: got %b required 0", tau_valid); end
    checks++; if (tau !== 8'd0) begin errors++; $display("FAIL mid_tau: got %0d required 0", tau); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b required 0", overrun); end
    checks++; if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready: got %b required 0", sif.s_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push(N - 1, 1000, low);
    repeat (4) @(negedge clk);
    checks++; if (det_reset !== 1'b0) begin errors++; $display("FAIL refill_early: det_reset %b required 0", det_reset); end
    push(1, 1000 + N - 1, low);
    @(negedge clk);
    checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL refill_launch: det_reset %b required 1", det_reset); end
    checks++; if (sample_at(0) !== 16'd1000) begin errors++; $display("FAIL snap3_s0: got %0d required 1000", sample_at(0)); end
    checks++; if (sample_at(295) !== 16'd1295) begin errors++; $display("FAIL snap3_s295: got %0d required 1295", sample_at(295)); end
  endtask

  task automatic test_coincident;
    int low;
    det_manual = 1'b1;
    det_manual_val = 1'b0;
    det_tau_val = 8'd42;
    wait_det_reset(1'b0, 20);
    push(HOP - 1, 2000, low);
    sif.s_valid = 1'b1;
    sif.s_data = DW'(2063);
    det_manual_val = 1'b1;
    @(negedge clk);
    sif.s_valid = 1'b0;
    checks++; if (tau_valid !== 1'b1) begin errors++; $display("FAIL coin_tv: got %b required 1", tau_valid); end
    checks++; if (tau !== 8'd42) begin errors++; $display("FAIL coin_tau: got %0d required 42", tau); end
    checks++; if (det_reset !== 1'b0) begin errors++; $display("FAIL coin_capture_reset: got %b required 0", det_reset); end
    @(negedge clk);
    checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL coin_relaunch: det_reset %b required 1", det_reset); end
    checks++; if (tau_valid !== 1'b0) begin errors++; $display("FAIL coin_tv_after: got %b required 0", tau_valid); end
    det_manual_val = 1'b0;
  endtask

  task automatic test_first_run_ignore;
    int hi;
    wait_det_reset(1'b0, 20);
    det_manual_val = 1'b1;
    @(negedge clk);
    det_manual_val = 1'b0;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (tau_valid === 1'b1) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL first_run_ignore: tau_valid %0d cycles required 0", hi); end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_fill_launch;
    test_detect;
    test_hop;
    test_overrun;
    test_mid_reset;
    test_coincident;
    test_first_run_ignore;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
